// File: rtl/waveform_clock_mc.sv
// Multi-channel programmable waveform clock generator: per-channel toggle (square)
// or pulse (strobe) output, with shadowed prescalers applied only at period boundaries.
module waveform_clock_mc #(
  parameter int unsigned CH_NUM    = 2,
  parameter int unsigned PSC_WIDTH = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic [CH_NUM-1:0]             wc_en_i,
  input  logic [CH_NUM-1:0]             wc_mode_i,
  input  logic [CH_NUM*PSC_WIDTH-1:0]   wc_psc_i,
  input  logic                          wc_load_i,
  input  logic                          wc_sync_i,
  output logic [CH_NUM-1:0]             wc_clk_o,
  output logic [CH_NUM-1:0]             wc_tick_o,
  output logic                          wc_load_pend_o
);

  localparam logic [PSC_WIDTH-1:0] ONE = PSC_WIDTH'(1);

  logic [PSC_WIDTH-1:0] shadow [CH_NUM];
  logic [PSC_WIDTH-1:0] active [CH_NUM];
  logic [PSC_WIDTH-1:0] cnt    [CH_NUM];
  logic [PSC_WIDTH-1:0] half   [CH_NUM];
  logic [CH_NUM-1:0]    mode_q;
  logic [CH_NUM-1:0]    pend;
  logic [CH_NUM-1:0]    clk_q;
  logic [CH_NUM-1:0]    tick_q;
  logic [CH_NUM-1:0]    idle;
  logic [CH_NUM-1:0]    term;
  logic [CH_NUM-1:0]    boundary;
  logic [CH_NUM-1:0]    xfer;

  // An idle channel has no waveform to truncate, so a pending shadow may land at once.
  always_comb begin
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      half[k]     = active[k] >> 1;
      idle[k]     = mode_q[k] ? (active[k] == '0) : (half[k] == '0);
      term[k]     = mode_q[k] ? (cnt[k] == active[k] - ONE) : (cnt[k] == half[k] - ONE);
      boundary[k] = !idle[k] && term[k] && (mode_q[k] || clk_q[k]);
      xfer[k]     = pend[k] && (!wc_en_i[k] ||
                    ((wc_mode_i[k] == mode_q[k]) && (idle[k] || boundary[k])));
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      for (int unsigned k = 0; k < CH_NUM; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
        cnt[k]    <= '0;
      end
      mode_q <= '0;
      pend   <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int unsigned k = 0; k < CH_NUM; k++) begin
        if (wc_sync_i) begin
          cnt[k]    <= '0;
          clk_q[k]  <= 1'b0;
          tick_q[k] <= 1'b0;
          mode_q[k] <= wc_mode_i[k];
          pend[k]   <= 1'b0;
          if (wc_load_i) begin
            shadow[k] <= wc_psc_i[k*PSC_WIDTH +: PSC_WIDTH];
            active[k] <= wc_psc_i[k*PSC_WIDTH +: PSC_WIDTH];
          end else if (pend[k]) begin
            active[k] <= shadow[k];
          end
        end else begin
          // Transfer uses the old shadow; a coincident load re-arms pending afterwards.
          if (xfer[k]) begin
            active[k] <= shadow[k];
            pend[k]   <= 1'b0;
          end
          if (wc_load_i) begin
            shadow[k] <= wc_psc_i[k*PSC_WIDTH +: PSC_WIDTH];
            pend[k]   <= 1'b1;
          end
          if (!wc_en_i[k] || (wc_mode_i[k] != mode_q[k]) || idle[k]) begin
            cnt[k]    <= '0;
            clk_q[k]  <= 1'b0;
            tick_q[k] <= 1'b0;
            mode_q[k] <= wc_mode_i[k];
          end else if (mode_q[k]) begin
            if (term[k]) begin
              cnt[k]    <= '0;
              clk_q[k]  <= 1'b1;
              tick_q[k] <= 1'b1;
            end else begin
              cnt[k]    <= cnt[k] + ONE;
              clk_q[k]  <= 1'b0;
              tick_q[k] <= 1'b0;
            end
          end else begin
            if (term[k]) begin
              cnt[k]    <= '0;
              clk_q[k]  <= ~clk_q[k];
              tick_q[k] <= ~clk_q[k];
            end else begin
              cnt[k]    <= cnt[k] + ONE;
              tick_q[k] <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign wc_clk_o       = clk_q;
  assign wc_tick_o      = tick_q;
  assign wc_load_pend_o = |pend;

endmodule

// File: tb/tb_waveform_clock_mc.sv
// Cycle-table bench for waveform_clock_mc (2 channels, 16-bit prescalers) plus
// hand-written sequences for asynchronous reset and post-reset first load.
module tb_waveform_clock_mc;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [1:0]  en      = '0;
  logic [1:0]  mode    = '0;
  logic [31:0] psc     = '0;
  logic        load    = 1'b0;
  logic        sync    = 1'b0;
  logic [1:0]  clk_o;
  logic [1:0]  tick_o;
  logic        pend_o;

  int vecs = 0;
  int miss = 0;

  waveform_clock_mc #(.CH_NUM(2), .PSC_WIDTH(16)) dut (
    .sys_clk_i      (sys_clk),
    .sys_rst_i      (sys_rst),
    .wc_en_i        (en),
    .wc_mode_i      (mode),
    .wc_psc_i       (psc),
    .wc_load_i      (load),
    .wc_sync_i      (sync),
    .wc_clk_o       (clk_o),
    .wc_tick_o      (tick_o),
    .wc_load_pend_o (pend_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  mode;
    logic [15:0] p0;
    logic [15:0] p1;
    logic        ld;
    logic        sy;
    logic [1:0]  clk;
    logic [1:0]  tick;
    logic        pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] e, input logic [1:0] m, input logic [15:0] a,
                     input logic [15:0] b, input logic l, input logic s,
                     input logic [1:0] c, input logic [1:0] t, input logic p);
    vec_t v;
    v.en = e; v.mode = m; v.p0 = a; v.p1 = b; v.ld = l; v.sy = s;
    v.clk = c; v.tick = t; v.pend = p;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got clk/tick/pend=%b_%b_%b, expected %b_%b_%b",
               name, got[4:3], got[2:1], got[0], exp[4:3], exp[2:1], exp[0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ch0 toggle psc=8, ch1 pulse psc=5, loaded while disabled
    add(2'b00, 2'b10, 16'd8, 16'd5, 1, 0, 2'b00, 2'b00, 1);
    add(2'b00, 2'b10, 16'd8, 16'd5, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b01, 2'b01, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b11, 2'b10, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b01, 2'b00, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b01, 2'b00, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b10, 2'b10, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b10, 16'd8, 16'd5, 0, 0, 2'b01, 2'b01, 0);
    // load ch0=4 during its high phase; high phase completes, then period 4
    add(2'b11, 2'b10, 16'd4, 16'd5, 1, 0, 2'b01, 2'b00, 1);
    add(2'b11, 2'b10, 16'd4, 16'd5, 0, 0, 2'b01, 2'b00, 1);
    add(2'b11, 2'b10, 16'd4, 16'd5, 0, 0, 2'b11, 2'b10, 1);
    add(2'b11, 2'b10, 16'd4, 16'd5, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b10, 16'd4, 16'd5, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b10, 16'd4, 16'd5, 0, 0, 2'b01, 2'b01, 0);
    add(2'b11, 2'b10, 16'd4, 16'd5, 0, 0, 2'b01, 2'b00, 0);
    add(2'b11, 2'b10, 16'd4, 16'd5, 0, 0, 2'b10, 2'b10, 0);
    add(2'b11, 2'b10, 16'd4, 16'd5, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b10, 16'd4, 16'd5, 0, 0, 2'b01, 2'b01, 0);
    // sync + load together: both toggle at psc=8, rise together 4 cycles later
    add(2'b11, 2'b00, 16'd8, 16'd8, 1, 1, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 16'd8, 16'd8, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 16'd8, 16'd8, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 16'd8, 16'd8, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 16'd8, 16'd8, 0, 0, 2'b11, 2'b11, 0);
    add(2'b11, 2'b00, 16'd8, 16'd8, 0, 0, 2'b11, 2'b00, 0);
    // toggle psc=7 -> period 6; toggle psc=1 -> idle
    add(2'b11, 2'b00, 16'd7, 16'd1, 1, 1, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 16'd7, 16'd1, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 16'd7, 16'd1, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 16'd7, 16'd1, 0, 0, 2'b01, 2'b01, 0);
    add(2'b11, 2'b00, 16'd7, 16'd1, 0, 0, 2'b01, 2'b00, 0);
    add(2'b11, 2'b00, 16'd7, 16'd1, 0, 0, 2'b01, 2'b00, 0);
    add(2'b11, 2'b00, 16'd7, 16'd1, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 16'd7, 16'd1, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 16'd7, 16'd1, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 16'd7, 16'd1, 0, 0, 2'b01, 2'b01, 0);
    // pulse psc=0 -> idle, pulse psc=1 -> constantly high; then disable ch1
    add(2'b11, 2'b11, 16'd0, 16'd1, 1, 1, 2'b00, 2'b00, 0);
    add(2'b11, 2'b11, 16'd0, 16'd1, 0, 0, 2'b10, 2'b10, 0);
    add(2'b11, 2'b11, 16'd0, 16'd1, 0, 0, 2'b10, 2'b10, 0);
    add(2'b11, 2'b11, 16'd0, 16'd1, 0, 0, 2'b10, 2'b10, 0);
    add(2'b01, 2'b11, 16'd0, 16'd1, 0, 0, 2'b00, 2'b00, 0);

    #2;
    check("reset_state", {clk_o, tick_o, pend_o}, 5'b00000);
    step();
    check("reset_held", {clk_o, tick_o, pend_o}, 5'b00000);
    sys_rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      en   = tbl[i].en;
      mode = tbl[i].mode;
      psc  = {tbl[i].p1, tbl[i].p0};
      load = tbl[i].ld;
      sync = tbl[i].sy;
      step();
      check($sformatf("row%0d", i), {clk_o, tick_o, pend_o},
            {tbl[i].clk, tbl[i].tick, tbl[i].pend});
    end

    // Async reset in the middle of a high phase with a load pending
    en = 2'b11; mode = 2'b00; psc = {16'd8, 16'd8}; load = 1'b1; sync = 1'b1;
    step();
    load = 1'b0; sync = 1'b0;
    step(); step(); step();
    load = 1'b1;
    step();
    load = 1'b0;
    check("pre_reset_high", {clk_o, tick_o, pend_o}, 5'b11111);
    #3;
    sys_rst = 1'b0;
    #1;
    check("async_reset", {clk_o, tick_o, pend_o}, 5'b00000);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("idle_after_reset%0d", i), {clk_o, tick_o, pend_o}, 5'b00000);
    end

    // First load after reset lands on an idle channel and starts it
    psc = {16'd4, 16'd4}; load = 1'b1;
    step();
    load = 1'b0;
    check("first_load_pend", {clk_o, tick_o, pend_o}, 5'b00001);
    step();
    check("first_load_apply", {clk_o, tick_o, pend_o}, 5'b00000);
    step();
    check("first_load_count", {clk_o, tick_o, pend_o}, 5'b00000);
    step();
    check("first_load_rise", {clk_o, tick_o, pend_o}, 5'b11110);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/waveform_clock_mc.md
WAVEFORM_CLOCK_MC -- requirements
Module: waveform_clock_mc

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 2: number of independent waveform clock channels (1..16).
REQ-002 The block SHALL have parameter PSC_WIDTH, default 16: prescaler width in bits (2..32).
REQ-003 The block SHALL have port sys_clk_i, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port sys_rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port wc_en_i, input, CH_NUM bits: per-channel run enable.
REQ-006 The block SHALL have port wc_mode_i, input, CH_NUM bits: per-channel mode; 0 = toggle (square clock), 1 = pulse (one-cycle strobe).
REQ-007 The block SHALL have port wc_psc_i, input, CH_NUM*PSC_WIDTH bits: packed prescalers; channel k at [k*PSC_WIDTH +: PSC_WIDTH].
REQ-008 The block SHALL have port wc_load_i, input, 1 bit: one-cycle request to capture wc_psc_i into all channel shadow registers.
REQ-009 The block SHALL have port wc_sync_i, input, 1 bit: one-cycle phase-alignment restart of all channels.
REQ-010 The block SHALL have port wc_clk_o, output, CH_NUM bits: registered waveform clock per channel.
REQ-011 The block SHALL have port wc_tick_o, output, CH_NUM bits: registered one-cycle strobe per channel period.
REQ-012 The block SHALL have port wc_load_pend_o, output, 1 bit: OR of all per-channel load-pending flags.

Function
REQ-013 Each channel SHALL hold a shadow prescaler, an active prescaler, a PSC_WIDTH-bit counter, a registered mode, a pending flag and registered outputs; only the active prescaler controls timing.
REQ-014 On wc_load_i high, every shadow SHALL capture its wc_psc_i field and every pending flag SHALL set; a load while pending overwrites the shadow, and the flag stays set.
REQ-015 A pending shadow SHALL transfer to active, and its flag SHALL clear, at that channel's period boundary (REQ-017/REQ-019), or on the next edge while the channel is disabled; a waveform period is never truncated.
REQ-016 Toggle mode: H = active>>1. The counter counts 0..H-1. At H-1 the clock toggles and the counter returns to 0. Output period = 2*H cycles, with 50% duty; the odd LSB is ignored.
REQ-017 Toggle-mode period boundary SHALL be terminal count with wc_clk_o = 1 (falling transition).
REQ-018 Toggle mode SHALL drive wc_tick_o high for exactly the first cycle in which wc_clk_o is 1 after a 0->1 transition.
REQ-019 Pulse mode: the counter counts 0..active-1. At active-1, wc_clk_o and wc_tick_o are high for the following cycle, and the counter returns to 0; terminal count is the boundary.
REQ-020 Idle prescaler SHALL hold clk, tick and counter at 0, with no boundaries generated: active < 2 in toggle mode; active = 0 in pulse mode. Pulse mode with active = 1 SHALL drive wc_clk_o and wc_tick_o constantly high.
REQ-021 A disabled channel (wc_en_i[k] = 0) SHALL clear its counter, wc_clk_o and wc_tick_o on the next edge.
REQ-022 After enable rises, a toggle channel SHALL first drive wc_clk_o high H cycles later (counter starts at 0).
REQ-023 A channel whose wc_mode_i differs from its registered mode SHALL, on the next edge, register the new mode, clear its counter and outputs, and restart.
REQ-024 wc_sync_i SHALL clear all counters, wc_clk_o and wc_tick_o, and apply all pending shadows, on the next edge; it has priority over count, toggle and mode logic.
REQ-025 On simultaneous wc_sync_i and wc_load_i, wc_psc_i SHALL go directly to the active registers and pending flags SHALL end cleared.
REQ-026 Counter and prescaler arithmetic SHALL be unsigned PSC_WIDTH-bit with no overflow, since the counter never exceeds active-1.

Reset
REQ-027 On sys_rst_i low, the block SHALL immediately, without a clock edge, clear wc_clk_o, wc_tick_o, wc_load_pend_o, all counters, shadow and active prescalers, registered modes and pending flags. All channels are idle until the first load.
REQ-028 Reset release SHALL take effect on the first sys_clk_i rising edge with sys_rst_i high; no output glitches during release.

Verification
REQ-029 Load ch0 psc=8 with mode 0, then enable -> wc_clk_o[0] first rises 4 cycles after enable, period 8 (4 high/4 low), wc_tick_o[0] one cycle per rise.
REQ-030 ch1 psc=5 with mode 1 -> wc_clk_o[1] = wc_tick_o[1], high 1 cycle every 5 cycles; psc=1 -> constantly high; psc=0 -> constantly 0.
REQ-031 Toggle mode with psc=7 -> period 6; psc=1 -> output stays 0, no ticks.
REQ-032 Running ch0 at psc=8, load 4 mid-high-phase -> wc_load_pend_o=1 until the falling transition, then the period becomes 4; no runt high or low phase.
REQ-033 ch0=8 and ch1=12 running out of phase; pulse wc_sync_i -> both outputs 0 next cycle; both rise together 4 cycles later if psc values are equal.
REQ-034 Assert sys_rst_i low mid-high-phase, between clock edges -> outputs 0 immediately; after release, outputs stay 0 with enable high until wc_load_i.
